// File: rtl/riscv_core_hazard_pkg.sv
// Shared types for the RV64 hazard unit: forwarding selects, MDU FSM states, x0 index.
package riscv_core_hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef enum logic {
    HU_IDLE = 1'b0,
    HU_BUSY = 1'b1
  } hu_state_e;

  localparam int REG_X0 = 0;

endpackage

// File: rtl/riscv_core_hazard_unit_mc_if.sv
// Datapath <-> hazard unit signal bundle; master is the datapath, slave the hazard unit.
// Perf counter outputs exist only when RISCV_HU_PERF_CNT_EN is defined.
interface riscv_core_hazard_unit_mc_if #(
  parameter int REG_ADDR_W = 5
`ifdef RISCV_HU_PERF_CNT_EN
  , parameter int CNT_W = 32
`endif
);

  logic [REG_ADDR_W-1:0] i_hazard_unit_rs1_id;
  logic [REG_ADDR_W-1:0] i_hazard_unit_rs2_id;
  logic [REG_ADDR_W-1:0] i_hazard_unit_rs1_ex;
  logic [REG_ADDR_W-1:0] i_hazard_unit_rs2_ex;
  logic [REG_ADDR_W-1:0] i_hazard_unit_rd_ex;
  logic [REG_ADDR_W-1:0] i_hazard_unit_rd_mem;
  logic [REG_ADDR_W-1:0] i_hazard_unit_rd_wb;
  logic                  i_hazard_unit_regwrite_mem;
  logic                  i_hazard_unit_regwrite_wb;
  logic                  i_hazard_unit_resultsrc0_ex;
  logic                  i_hazard_unit_pcsrc_ex;
  logic                  i_hazard_unit_mdu_start_ex;
  logic                  i_hazard_unit_mdu_done_ex;
  logic                  i_hazard_unit_kill;

  logic [1:0]            o_hazard_unit_forwarda_ex;
  logic [1:0]            o_hazard_unit_forwardb_ex;
  logic                  o_hazard_unit_stall_if;
  logic                  o_hazard_unit_stall_id;
  logic                  o_hazard_unit_stall_ex;
  logic                  o_hazard_unit_flush_id;
  logic                  o_hazard_unit_flush_ex;
  logic                  o_hazard_unit_flush_mem;
  logic                  o_hazard_unit_mdu_busy;
  logic                  o_hazard_unit_mdu_timeout;
`ifdef RISCV_HU_PERF_CNT_EN
  logic [CNT_W-1:0]      o_hazard_unit_stall_cnt;
  logic [CNT_W-1:0]      o_hazard_unit_flush_cnt;
`endif

  modport master (
    output i_hazard_unit_rs1_id, i_hazard_unit_rs2_id,
    output i_hazard_unit_rs1_ex, i_hazard_unit_rs2_ex, i_hazard_unit_rd_ex,
    output i_hazard_unit_rd_mem, i_hazard_unit_rd_wb,
    output i_hazard_unit_regwrite_mem, i_hazard_unit_regwrite_wb,
    output i_hazard_unit_resultsrc0_ex, i_hazard_unit_pcsrc_ex,
    output i_hazard_unit_mdu_start_ex, i_hazard_unit_mdu_done_ex, i_hazard_unit_kill,
    input  o_hazard_unit_forwarda_ex, o_hazard_unit_forwardb_ex,
    input  o_hazard_unit_stall_if, o_hazard_unit_stall_id, o_hazard_unit_stall_ex,
    input  o_hazard_unit_flush_id, o_hazard_unit_flush_ex, o_hazard_unit_flush_mem,
    input  o_hazard_unit_mdu_busy, o_hazard_unit_mdu_timeout
`ifdef RISCV_HU_PERF_CNT_EN
    , input o_hazard_unit_stall_cnt, o_hazard_unit_flush_cnt
`endif
  );

  modport slave (
    input  i_hazard_unit_rs1_id, i_hazard_unit_rs2_id,
    input  i_hazard_unit_rs1_ex, i_hazard_unit_rs2_ex, i_hazard_unit_rd_ex,
    input  i_hazard_unit_rd_mem, i_hazard_unit_rd_wb,
    input  i_hazard_unit_regwrite_mem, i_hazard_unit_regwrite_wb,
    input  i_hazard_unit_resultsrc0_ex, i_hazard_unit_pcsrc_ex,
    input  i_hazard_unit_mdu_start_ex, i_hazard_unit_mdu_done_ex, i_hazard_unit_kill,
    output o_hazard_unit_forwarda_ex, o_hazard_unit_forwardb_ex,
    output o_hazard_unit_stall_if, o_hazard_unit_stall_id, o_hazard_unit_stall_ex,
    output o_hazard_unit_flush_id, o_hazard_unit_flush_ex, o_hazard_unit_flush_mem,
    output o_hazard_unit_mdu_busy, o_hazard_unit_mdu_timeout
`ifdef RISCV_HU_PERF_CNT_EN
    , output o_hazard_unit_stall_cnt, o_hazard_unit_flush_cnt
`endif
  );

endinterface

// File: rtl/riscv_core_hazard_mdu_fsm.sv
// Multi-cycle MDU tracker: IDLE/BUSY FSM, busy-cycle watchdog and sticky timeout flag.
module riscv_core_hazard_mdu_fsm
  import riscv_core_hazard_pkg::*;
#(
  parameter int MDU_MAX_CYCLES = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic mdu_start_i,
  input  logic mdu_done_i,
  input  logic kill_i,
  output logic mdu_stall_o,
  output logic wd_hit_o,
  output logic mdu_busy_o,
  output logic mdu_timeout_o
);

  localparam int                    BusyCntW = $clog2(MDU_MAX_CYCLES);
  localparam logic [BusyCntW-1:0]   WdLimit  = BusyCntW'(MDU_MAX_CYCLES - 1);

  hu_state_e           state_q, state_d;
  logic [BusyCntW-1:0] busyCnt_q, busyCnt_d;
  logic                timeout_q, timeout_d;
  logic                wdHit;

  assign wdHit = (state_q == HU_BUSY) && (busyCnt_q == WdLimit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= HU_IDLE;
      busyCnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      busyCnt_q <= busyCnt_d;
      timeout_q <= timeout_d;
    end
  end

  // Counter is cleared on every exit so it never wraps and wdHit cannot linger.
  always_comb begin
    state_d   = state_q;
    busyCnt_d = busyCnt_q;
    timeout_d = timeout_q | wdHit;
    unique case (state_q)
      HU_IDLE: begin
        if (mdu_start_i && !mdu_done_i && !kill_i) begin
          state_d   = HU_BUSY;
          busyCnt_d = '0;
        end
      end
      HU_BUSY: begin
        if (kill_i || mdu_done_i || wdHit) begin
          state_d   = HU_IDLE;
          busyCnt_d = '0;
        end else begin
          busyCnt_d = busyCnt_q + BusyCntW'(1);
        end
      end
      default: begin
        state_d   = HU_IDLE;
        busyCnt_d = '0;
      end
    endcase
  end

  always_comb begin
    mdu_stall_o = 1'b0;
    unique case (state_q)
      HU_IDLE: mdu_stall_o = mdu_start_i && !mdu_done_i && !kill_i;
      HU_BUSY: mdu_stall_o = !mdu_done_i && !kill_i && !wdHit;
      default: mdu_stall_o = 1'b0;
    endcase
    wd_hit_o      = wdHit;
    mdu_busy_o    = (state_q == HU_BUSY);
    mdu_timeout_o = timeout_q;
  end

endmodule

// File: rtl/riscv_core_hazard_unit_mc.sv
// RV64 5-stage hazard unit: forwarding, load-use stall, branch flush, MDU stall/watchdog, kill.
// Define RISCV_HU_PERF_CNT_EN to add saturating stall/flush performance counters.
module riscv_core_hazard_unit_mc
  import riscv_core_hazard_pkg::*;
#(
  parameter int REG_ADDR_W     = 5,
  parameter int MDU_MAX_CYCLES = 64
`ifdef RISCV_HU_PERF_CNT_EN
  , parameter int CNT_W        = 32
`endif
) (
  input logic                        clk,
  input logic                        rst_n,
  riscv_core_hazard_unit_mc_if.slave hu
);

  localparam logic [REG_ADDR_W-1:0] X0 = REG_ADDR_W'(REG_X0);

  function automatic fwd_sel_e fwdSelect(
    input logic                  regwriteMem,
    input logic [REG_ADDR_W-1:0] rdMem,
    input logic                  regwriteWb,
    input logic [REG_ADDR_W-1:0] rdWb,
    input logic [REG_ADDR_W-1:0] rs
  );
    if (regwriteMem && (rdMem != X0) && (rdMem == rs)) begin
      return FWD_MEM;
    end else if (regwriteWb && (rdWb != X0) && (rdWb == rs)) begin
      return FWD_WB;
    end
    return FWD_RF;
  endfunction

  logic lwStall;
  logic mduStall;
  logic wdHit;
  logic kill;
  logic pcsrcFlush;
  logic stallFront;

  assign hu.o_hazard_unit_forwarda_ex = fwdSelect(hu.i_hazard_unit_regwrite_mem,
                                                  hu.i_hazard_unit_rd_mem,
                                                  hu.i_hazard_unit_regwrite_wb,
                                                  hu.i_hazard_unit_rd_wb,
                                                  hu.i_hazard_unit_rs1_ex);
  assign hu.o_hazard_unit_forwardb_ex = fwdSelect(hu.i_hazard_unit_regwrite_mem,
                                                  hu.i_hazard_unit_rd_mem,
                                                  hu.i_hazard_unit_regwrite_wb,
                                                  hu.i_hazard_unit_rd_wb,
                                                  hu.i_hazard_unit_rs2_ex);

  assign lwStall = hu.i_hazard_unit_resultsrc0_ex && (hu.i_hazard_unit_rd_ex != X0) &&
                   ((hu.i_hazard_unit_rd_ex == hu.i_hazard_unit_rs1_id) ||
                    (hu.i_hazard_unit_rd_ex == hu.i_hazard_unit_rs2_id));

  assign kill = hu.i_hazard_unit_kill;

  riscv_core_hazard_mdu_fsm #(
    .MDU_MAX_CYCLES (MDU_MAX_CYCLES)
  ) u_mdu_fsm (
    .clk           (clk),
    .rst_n         (rst_n),
    .mdu_start_i   (hu.i_hazard_unit_mdu_start_ex),
    .mdu_done_i    (hu.i_hazard_unit_mdu_done_ex),
    .kill_i        (kill),
    .mdu_stall_o   (mduStall),
    .wd_hit_o      (wdHit),
    .mdu_busy_o    (hu.o_hazard_unit_mdu_busy),
    .mdu_timeout_o (hu.o_hazard_unit_mdu_timeout)
  );

  // A branch resolved in EX is ignored while EX is frozen holding the MDU op.
  assign pcsrcFlush = !mduStall && hu.i_hazard_unit_pcsrc_ex;
  assign stallFront = lwStall || mduStall;

  assign hu.o_hazard_unit_stall_if  = stallFront;
  assign hu.o_hazard_unit_stall_id  = stallFront;
  assign hu.o_hazard_unit_stall_ex  = mduStall;
  assign hu.o_hazard_unit_flush_mem = mduStall || kill || wdHit;
  assign hu.o_hazard_unit_flush_ex  = kill || wdHit || (!mduStall && lwStall) || pcsrcFlush;
  assign hu.o_hazard_unit_flush_id  = kill || wdHit || pcsrcFlush;

`ifdef RISCV_HU_PERF_CNT_EN
  logic [CNT_W-1:0] stallCnt_q, stallCnt_d;
  logic [CNT_W-1:0] flushCnt_q, flushCnt_d;

  // Both counters stick at all-ones rather than wrapping.
  always_comb begin
    stallCnt_d = stallCnt_q;
    flushCnt_d = flushCnt_q;
    if (stallFront && (stallCnt_q != '1)) begin
      stallCnt_d = stallCnt_q + CNT_W'(1);
    end
    if (pcsrcFlush && (flushCnt_q != '1)) begin
      flushCnt_d = flushCnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stallCnt_q <= '0;
      flushCnt_q <= '0;
    end else begin
      stallCnt_q <= stallCnt_d;
      flushCnt_q <= flushCnt_d;
    end
  end

  assign hu.o_hazard_unit_stall_cnt = stallCnt_q;
  assign hu.o_hazard_unit_flush_cnt = flushCnt_q;
`endif

endmodule

// File: doc/riscv_core_hazard_unit_mc.md
Name: riscv_core_hazard_unit_mc

Overview:
Next-generation hazard unit for the RV64IMAC 5-stage pipeline (IF/ID/EX/MEM/WB). It keeps the existing duties: MEM/WB forwarding, load-use stall, and branch flush. It adds a registered FSM that stalls the front end while the multi-cycle M-extension unit (MDU) in EX is busy, a busy-cycle watchdog, and a kill/abort path. The block sits beside the datapath and drives the stall and flush enables of the pipeline registers.

Parameters:
REG_ADDR_W, 5, register index width.
MDU_MAX_CYCLES, 64, watchdog limit on BUSY cycles (>=2).
CNT_W, 32, width of the performance counters (optional feature only).

Ports:
clk  in  1  core clock.
rst_n  in  1  asynchronous, active-low reset.
i_hazard_unit_rs1_id / rs2_id  in  REG_ADDR_W  sources in ID.
i_hazard_unit_rs1_ex / rs2_ex / rd_ex  in  REG_ADDR_W  sources/dest in EX.
i_hazard_unit_rd_mem / rd_wb  in  REG_ADDR_W  dest in MEM / WB.
i_hazard_unit_regwrite_mem / regwrite_wb  in  1  write enables.
i_hazard_unit_resultsrc0_ex  in  1  EX instruction is a load.
i_hazard_unit_pcsrc_ex  in  1  taken branch/jump in EX.
i_hazard_unit_mdu_start_ex  in  1  MDU op present in EX (level, valid while in EX).
i_hazard_unit_mdu_done_ex  in  1  MDU result valid this cycle.
i_hazard_unit_kill  in  1  trap/exception: abort in-flight work.
o_hazard_unit_forwarda_ex / forwardb_ex  out  2  00 regfile, 01 WB, 10 MEM.
o_hazard_unit_stall_if / stall_id / stall_ex  out  1  hold stage register.
o_hazard_unit_flush_id / flush_ex / flush_mem  out  1  bubble stage register.
o_hazard_unit_mdu_busy  out  1  FSM in BUSY.
o_hazard_unit_mdu_timeout  out  1  sticky watchdog flag.

Behaviour:
- Reset (asynchronous, rst_n low):
  - state=IDLE, busy counter=0, mdu_timeout=0.
  - Combinational outputs follow the IDLE equations below.
- Forwarding (combinational), per source:
  - 10 if regwrite_mem && rd_mem!=0 && rd_mem==rs_ex.
  - Else 01 if regwrite_wb && rd_wb!=0 && rd_wb==rs_ex.
  - Else 00. MEM has priority over WB.
- lw_stall = resultsrc0_ex && rd_ex!=0 && (rd_ex==rs1_id || rd_ex==rs2_id).
- mdu_stall:
  - IDLE: mdu_start_ex && !mdu_done_ex && !kill.
  - BUSY: !mdu_done_ex && !kill && !wd_hit.
  - wd_hit = busy counter == MDU_MAX_CYCLES-1.
- Stall outputs:
  - stall_if = stall_id = lw_stall || mdu_stall.
  - stall_ex = mdu_stall.
- Flush outputs:
  - flush_mem = mdu_stall || kill || wd_hit (bubble into MEM while EX is frozen).
  - flush_ex = kill || wd_hit || (!mdu_stall && (lw_stall || pcsrc_ex)).
  - flush_id = kill || wd_hit || (!mdu_stall && pcsrc_ex).
- pcsrc_ex is ignored while mdu_stall (EX holds the MDU op).
- FSM (registered):
  - IDLE->BUSY when mdu_start_ex && !mdu_done_ex && !kill; counter cleared.
  - BUSY: counter increments each cycle.
  - BUSY->IDLE on mdu_done_ex. Stall drops in the done cycle, so EX advances the same edge.
  - BUSY->IDLE on kill.
  - BUSY->IDLE on wd_hit; also set mdu_timeout (sticky until reset).
- Single-cycle MDU (start && done in the same IDLE cycle): no stall, FSM stays IDLE.
- kill has priority over done and start in the same cycle.
- kill in IDLE: flushes asserted, no state change.
- Counter width: $clog2(MDU_MAX_CYCLES); no wrap is reachable.
- mdu_busy = (state==BUSY).

Optional Feature:
RISCV_HU_PERF_CNT_EN:
- Defined: adds outputs o_hazard_unit_stall_cnt [CNT_W] and o_hazard_unit_flush_cnt [CNT_W].
  - stall_cnt counts cycles with stall_if=1.
  - flush_cnt counts cycles with pcsrc-caused flush_ex.
  - Both reset to 0 and saturate at all-ones.
- Undefined: ports and logic absent; all other behaviour identical.

Decomposition:
- Package riscv_core_hazard_pkg:
  - enum fwd_sel_e (FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10).
  - enum hu_state_e (HU_IDLE, HU_BUSY).
  - localparam REG_X0=0.
- Sub-module riscv_core_hazard_mdu_fsm holds the FSM, watchdog counter and timeout flag. Outputs mdu_stall and wd_hit; combinational forwarding stays in the top.

Test Plan:
1. Forward priority: regwrite_mem=1, rd_mem=5; regwrite_wb=1, rd_wb=5; rs1_ex=5 -> forwarda=10. With rd_mem=0 -> forwarda=01. With rs2_ex=0 and rd_wb=0 -> forwardb=00.
2. Load-use: resultsrc0_ex=1, rd_ex=19, rs1_id=19 -> stall_if=stall_id=1, flush_ex=1, stall_ex=0. Same with rd_ex=0 -> all 0.
3. MDU divide: start at cycle T, done at T+33 -> stall_if/id/ex and flush_mem high T..T+32, low at T+33; mdu_busy high T+1..T+33; IDLE at T+34.
4. Single-cycle MUL: start=done=1 -> no stall, mdu_busy stays 0. Branch (pcsrc_ex=1) while BUSY -> flush_id=flush_ex=0.
5. Watchdog, MDU_MAX_CYCLES=8, done never asserted -> wd_hit 8 cycles after the IDLE->BUSY edge (stall held 8 cycles). At that cycle: flush_id/ex/mem=1, mdu_timeout=1 next edge and sticky. Kill mid-BUSY -> flushes, IDLE next edge. rst_n low mid-BUSY -> IDLE, timeout cleared asynchronously.
6. With RISCV_HU_PERF_CNT_EN, CNT_W=4: 20 stall cycles -> stall_cnt=4'hF (saturated); reset -> 0.
